// File: rtl/de2_qsys_cpu_oci_dct_ctrl.sv
// Trace atom packer: packs 2-bit atoms into words of up to MAX_ATOMS atoms and
// hands them to trace memory with one word of double buffering.
module de2_qsys_cpu_oci_dct_ctrl #(
    parameter int unsigned MAX_ATOMS = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trace_en,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    input  logic        flush,
    input  logic        tm_wr_ack,
    output logic        tm_wr_req,
    output logic [33:0] tm_wr_data,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow,
    output logic        busy
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t      state, state_n;
    logic [29:0] buffer_n;
    logic [3:0]  count_n;
    logic        req_n;
    logic [33:0] data_n;
    logic        ovf_n;
    logic        fpend, fpend_n;
    logic        en_q;
    logic        take;
    logic        full;
    logic [29:0] sh_buffer;
    logic [3:0]  sh_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dct_buffer <= '0;
            dct_count  <= '0;
            tm_wr_req  <= 1'b0;
            tm_wr_data <= '0;
            overflow   <= 1'b0;
            fpend      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state      <= state_n;
            dct_buffer <= buffer_n;
            dct_count  <= count_n;
            tm_wr_req  <= req_n;
            tm_wr_data <= data_n;
            overflow   <= ovf_n;
            fpend      <= fpend_n;
            en_q       <= trace_en;
        end
    end

    always_comb begin
        take      = atom_valid & trace_en;
        full      = (dct_count == MAX_CNT);
        sh_buffer = {dct_buffer[27:0], atom};
        sh_count  = dct_count + 4'd1;
        state_n   = state;
        buffer_n  = dct_buffer;
        count_n   = dct_count;
        req_n     = tm_wr_req;
        data_n    = tm_wr_data;
        fpend_n   = fpend;
        // a trace_en rising edge clears overflow; a drop in the same cycle wins
        ovf_n     = overflow & ~(trace_en & ~en_q);

        case (state)
            IDLE, RUN: begin
                if (take) begin
                    buffer_n = sh_buffer;
                    count_n  = sh_count;
                end
                fpend_n = 1'b0;
                // trace_en low drains the partial word exactly like a flush
                if ((take && sh_count == MAX_CNT) ||
                    ((flush | fpend | ~trace_en) && dct_count != 4'd0)) begin
                    data_n   = {count_n, buffer_n};
                    req_n    = 1'b1;
                    buffer_n = '0;
                    count_n  = '0;
                    state_n  = PEND;
                end else if (!trace_en) begin
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end

            PEND: begin
                if (tm_wr_ack) begin
                    if (full) begin
                        data_n   = {MAX_CNT, dct_buffer};
                        buffer_n = take ? {28'b0, atom} : '0;
                        count_n  = take ? 4'd1 : 4'd0;
                        fpend_n  = 1'b0;
                    end else if (take && sh_count == MAX_CNT) begin
                        data_n   = {MAX_CNT, sh_buffer};
                        buffer_n = '0;
                        count_n  = '0;
                        fpend_n  = 1'b0;
                    end else begin
                        req_n   = 1'b0;
                        state_n = RUN;
                        if (take) begin
                            buffer_n = sh_buffer;
                            count_n  = sh_count;
                        end
                        if (flush && dct_count != 4'd0) fpend_n = 1'b1;
                    end
                end else begin
                    if (full) begin
                        if (take) ovf_n = 1'b1;
                    end else if (take) begin
                        buffer_n = sh_buffer;
                        count_n  = sh_count;
                    end
                    if (flush && dct_count != 4'd0) fpend_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign busy = (dct_count != 4'd0) | tm_wr_req;

endmodule

// File: tb/tb_de2_qsys_cpu_oci_dct_ctrl.sv
// Bench for the trace atom packer: directed table, hand sequences for the
// double-buffer corners, and random traffic against a queue-based model.
module tb_de2_qsys_cpu_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en = 1'b0, atom_valid = 1'b0, flush = 1'b0, tm_wr_ack = 1'b0;
    logic [1:0]  atom = 2'd0;
    logic        tm_wr_req;
    logic [33:0] tm_wr_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow, busy;

    logic        t4_en = 1'b0, t4_av = 1'b0, t4_flush = 1'b0, t4_ack = 1'b0;
    logic [1:0]  t4_atom = 2'd0;
    logic        t4_req;
    logic [33:0] t4_data;
    logic [29:0] t4_buffer;
    logic [3:0]  t4_count;
    logic        t4_ovf, t4_busy;

    always #5 clk = ~clk;

    de2_qsys_cpu_oci_dct_ctrl dut (
        .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .atom_valid(atom_valid),
        .atom(atom), .flush(flush), .tm_wr_ack(tm_wr_ack), .tm_wr_req(tm_wr_req),
        .tm_wr_data(tm_wr_data), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .overflow(overflow), .busy(busy)
    );

    de2_qsys_cpu_oci_dct_ctrl #(.MAX_ATOMS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .trace_en(t4_en), .atom_valid(t4_av),
        .atom(t4_atom), .flush(t4_flush), .tm_wr_ack(t4_ack), .tm_wr_req(t4_req),
        .tm_wr_data(t4_data), .dct_buffer(t4_buffer), .dct_count(t4_count),
        .overflow(t4_ovf), .busy(t4_busy)
    );

    int unsigned n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: partial word kept as a queue of atoms, held word as a value.
    int unsigned MAXM = 15;
    int          part[$];
    bit          pend, fpend_m, ovf_m, en_q_m;
    logic [33:0] held;

    function automatic logic [29:0] pack();
        logic [29:0] v;
        v = '0;
        foreach (part[i]) v = (v << 2) | 30'(part[i]);
        return v;
    endfunction

    task automatic issue();
        held = {4'(part.size()), pack()};
        part.delete();
        pend = 1'b1;
    endtask

    task automatic model_reset();
        part.delete();
        pend = 0; fpend_m = 0; ovf_m = 0; en_q_m = 0; held = '0;
    endtask

    task automatic model_step(input bit ten, input bit av, input bit [1:0] a,
                              input bit fl, input bit ack);
        int  old;
        bit  take, drop;
        old  = part.size();
        take = av && ten;
        drop = 0;
        if (!pend) begin
            if (take) part.push_back(int'(a));
            if ((take && part.size() == MAXM) || ((fl || fpend_m || !ten) && old > 0))
                issue();
            fpend_m = 0;
        end else if (ack) begin
            if (old == MAXM) begin
                issue();
                if (take) part.push_back(int'(a));
                fpend_m = 0;
            end else if (take && old + 1 == MAXM) begin
                part.push_back(int'(a));
                issue();
                fpend_m = 0;
            end else begin
                pend = 0;
                if (take) part.push_back(int'(a));
                if (fl && old > 0) fpend_m = 1;
            end
        end else begin
            if (old == MAXM) drop = take;
            else if (take) part.push_back(int'(a));
            if (fl && old > 0) fpend_m = 1;
        end
        ovf_m  = (ovf_m && !(ten && !en_q_m)) || drop;
        en_q_m = ten;
    endtask

    task automatic check_model();
        chk("m_req",   64'(tm_wr_req),  64'(pend));
        chk("m_data",  64'(tm_wr_data), 64'(held));
        chk("m_buf",   64'(dct_buffer), 64'(pack()));
        chk("m_count", 64'(dct_count),  64'(part.size()));
        chk("m_ovf",   64'(overflow),   64'(ovf_m));
        chk("m_busy",  64'(busy),       64'(part.size() != 0 || pend));
    endtask

    task automatic cyc(input bit ten, input bit av, input bit [1:0] a,
                       input bit fl, input bit ack);
        trace_en = ten; atom_valid = av; atom = a; flush = fl; tm_wr_ack = ack;
        @(posedge clk);
        model_step(ten, av, a, fl, ack);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        trace_en = 0; atom_valid = 0; flush = 0; tm_wr_ack = 0; atom = 0;
        model_reset();
        #1;
        chk("rst_req",   64'(tm_wr_req),  0);
        chk("rst_data",  64'(tm_wr_data), 0);
        chk("rst_buf",   64'(dct_buffer), 0);
        chk("rst_count", 64'(dct_count),  0);
        chk("rst_ovf",   64'(overflow),   0);
        chk("rst_busy",  64'(busy),       0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit        ten, av;
        bit [1:0]  a;
        bit        fl, ack;
        bit        req;
        bit [3:0]  cnt;
        bit [33:0] data;
        bit        busy;
    } vec_t;

    localparam logic [33:0] W32 = {4'd3, 30'h39};
    localparam logic [33:0] W01 = {4'd15, 30'h15555555};
    localparam logic [33:0] W10 = {4'd15, 30'h2AAAAAAA};

    initial begin
        vec_t tbl[$];
        bit   req_dropped;
        int   reqs;
        bit [1:0] pat [4];

        reset_n = 1'b1;
        #2;
        do_reset();

        // 3 atoms then flush, ack; then 15 atoms of 01 with ack tied high
        tbl.push_back('{1, 1, 2'b11, 0, 0, 0, 4'd1, 34'd0, 1});
        tbl.push_back('{1, 1, 2'b10, 0, 0, 0, 4'd2, 34'd0, 1});
        tbl.push_back('{1, 1, 2'b01, 0, 0, 0, 4'd3, 34'd0, 1});
        tbl.push_back('{1, 0, 2'b00, 1, 0, 1, 4'd0, W32,   1});
        tbl.push_back('{1, 0, 2'b00, 0, 1, 0, 4'd0, W32,   0});
        for (int i = 1; i <= 14; i++)
            tbl.push_back('{1, 1, 2'b01, 0, 1, 0, 4'(i), W32, 1});
        tbl.push_back('{1, 1, 2'b01, 0, 1, 1, 4'd0, W01, 1});
        tbl.push_back('{1, 0, 2'b00, 0, 1, 0, 4'd0, W01, 0});
        foreach (tbl[i]) begin
            cyc(tbl[i].ten, tbl[i].av, tbl[i].a, tbl[i].fl, tbl[i].ack);
            chk("tbl_req",   64'(tm_wr_req),  64'(tbl[i].req));
            chk("tbl_count", 64'(dct_count),  64'(tbl[i].cnt));
            chk("tbl_data",  64'(tm_wr_data), 64'(tbl[i].data));
            chk("tbl_busy",  64'(busy),       64'(tbl[i].busy));
        end

        // Buffer full in PEND, atom and ack arrive together: nothing lost
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'b01, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'b10, 0, 0);
        chk("full_count", 64'(dct_count), 15);
        chk("full_req",   64'(tm_wr_req), 1);
        cyc(1, 1, 2'b11, 0, 1);
        chk("b2b_count", 64'(dct_count),  1);
        chk("b2b_buf",   64'(dct_buffer), 3);
        chk("b2b_data",  64'(tm_wr_data), 64'(W10));
        chk("b2b_req",   64'(tm_wr_req),  1);
        chk("b2b_ovf",   64'(overflow),   0);

        // 31 atoms without ack: last one dropped, then back-to-back handover
        do_reset();
        req_dropped = 0;
        for (int i = 0; i < 31; i++) begin
            cyc(1, 1, (i < 15) ? 2'b01 : ((i < 30) ? 2'b10 : 2'b11), 0, 0);
            if (i >= 14 && tm_wr_req !== 1'b1) req_dropped = 1;
        end
        chk("ovf_set",   64'(overflow),   1);
        chk("ovf_count", 64'(dct_count),  15);
        chk("ovf_buf",   64'(dct_buffer), 30'h2AAAAAAA);
        chk("ovf_data",  64'(tm_wr_data), 64'(W01));
        cyc(1, 0, 2'b00, 0, 1);
        if (tm_wr_req !== 1'b1) req_dropped = 1;
        chk("ovf_req_gap", 64'(req_dropped), 0);
        chk("ovf_data2",   64'(tm_wr_data),  64'(W10));
        chk("ovf_sticky",  64'(overflow),    1);

        // Reset while a request is held and a partial word exists
        do_reset();
        for (int i = 0; i < 22; i++) cyc(1, 1, 2'(i), 0, 0);
        chk("pre_rst_req",   64'(tm_wr_req), 1);
        chk("pre_rst_count", 64'(dct_count), 7);
        do_reset();
        req_dropped = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 1, 2'(i), 0, 1);
            if (tm_wr_req !== 1'b0) req_dropped = 1;
        end
        chk("post_rst_noreq", 64'(req_dropped), 0);
        cyc(1, 1, 2'b00, 0, 1);
        chk("post_rst_req", 64'(tm_wr_req), 1);

        // MAX_ATOMS=4 instance: 8 atoms with ack high give two 4-atom words
        pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3; pat[3] = 2'd0;
        reqs = 0;
        for (int i = 0; i < 9; i++) begin
            t4_en = 1; t4_av = (i < 8); t4_atom = pat[i % 4]; t4_ack = 1;
            cyc(0, 0, 2'b00, 0, 0);
            if (t4_req === 1'b1) begin
                reqs++;
                chk("m4_data", 64'(t4_data), 64'({4'd4, 30'h6C}));
            end
        end
        chk("m4_reqs", 64'(reqs), 2);
        t4_en = 0; t4_av = 0; t4_ack = 0;

        // Random traffic against the model
        do_reset();
        begin
            bit ten;
            ten = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(99) < 3) ten = ~ten;
                if ($urandom_range(999) < 3) begin
                    do_reset();
                end else begin
                    cyc(ten, $urandom_range(99) < 70, 2'($urandom),
                        $urandom_range(99) < 5, $urandom_range(99) < 35);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
